// File: rtl/tpu_host_driver.sv
// tpu_host_driver: bus initiator that runs one full TPU matmul job per start.
// Define TPU_DRV_CLRC_EN to zero every C word before loading A and B.
module tpu_host_driver #(
    parameter int DIM         = 8,
    parameter int BITS_C      = 16,
    parameter int ADDRW       = 16,
    parameter int DATAW       = 64,
    parameter int SRC_AW      = 8,
    parameter int WAIT_CYCLES = 3 * DIM
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [SRC_AW-1:0]        src_base,
    output logic                     busy,
    output logic                     done,
    output logic [SRC_AW-1:0]        src_addr,
    input  logic [DATAW-1:0]         src_rdata,
    output logic                     res_we,
    output logic [$clog2(2*DIM)-1:0] res_addr,
    output logic [DATAW-1:0]         res_data,
    output logic                     tpu_r_w,
    output logic [ADDRW-1:0]         tpu_addr,
    output logic [DATAW-1:0]         tpu_wdata,
    input  logic [DATAW-1:0]         tpu_rdata
);
    localparam int NW   = 2 * DIM;
    localparam int CWPR = (DIM * BITS_C) / DATAW;
    localparam int NRES = DIM * CWPR;
    localparam int RAW  = $clog2(2 * DIM);
    localparam int CMAX = (WAIT_CYCLES > NW) ? WAIT_CYCLES : NW;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR_C, S_LOAD, S_TRIG, S_WAIT, S_READ, S_DONE
    } state_t;

    state_t              state, state_nxt;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic [SRC_AW-1:0]   base_q;

    // C word k lives in row k/CWPR, half k%CWPR
    function automatic logic [ADDRW-1:0] c_addr(input logic [CW-1:0] k);
        int ki;
        ki = int'(k);
        return ADDRW'(32'h0300 + 16 * (ki / CWPR) + 8 * (ki % CWPR));
    endfunction

    function automatic logic [ADDRW-1:0] ab_addr(input logic [CW-1:0] c);
        int j;
        j = int'(c) - 1;
        if (j < DIM) return ADDRW'(32'h0100 + 8 * j);
        return ADDRW'(32'h0200 + 8 * (j - DIM));
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            base_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == S_IDLE && start) base_q <= src_base;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy      = (state != S_IDLE);
        done      = 1'b0;
        src_addr  = '0;
        tpu_r_w   = 1'b0;
        tpu_addr  = '0;
        tpu_wdata = '0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
`ifdef TPU_DRV_CLRC_EN
                    state_nxt = S_CLR_C;
`else
                    state_nxt = S_LOAD;
`endif
                    cnt_nxt = '0;
                end
            end
`ifdef TPU_DRV_CLRC_EN
            S_CLR_C: begin
                tpu_r_w  = 1'b1;
                tpu_addr = c_addr(cnt);
                if (cnt == CW'(NRES - 1)) begin
                    state_nxt = S_LOAD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
`endif
            // source read leads the bus write by one cycle
            S_LOAD: begin
                if (cnt < CW'(NW)) src_addr = base_q + SRC_AW'(cnt);
                if (cnt != '0) begin
                    tpu_r_w   = 1'b1;
                    tpu_addr  = ab_addr(cnt);
                    tpu_wdata = src_rdata;
                end
                if (cnt == CW'(NW)) begin
                    state_nxt = S_TRIG;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_TRIG: begin
                tpu_r_w   = 1'b1;
                tpu_addr  = ADDRW'(32'h0400);
                state_nxt = S_WAIT;
                cnt_nxt   = '0;
            end
            S_WAIT: begin
                if (cnt == CW'(WAIT_CYCLES - 1)) begin
                    state_nxt = S_READ;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_READ: begin
                tpu_addr = c_addr(cnt);
                if (cnt == CW'(NRES - 1)) begin
                    state_nxt = S_DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_we   <= 1'b0;
            res_addr <= '0;
            res_data <= '0;
        end else begin
            res_we <= (state == S_READ);
            if (state == S_READ) begin
                res_addr <= RAW'(cnt);
                res_data <= tpu_rdata;
            end
        end
    end

endmodule
